ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Execute-to-memory pipeline stage placed directly downstream of the ALU. It captures the ALU result and the instruction's control fields into the EX/MEM register and presents them to the memory stage with a valid/ready handshake. The ALU's multiply and divide results come from pipelined arithmetic units, so this block also counts their latency and holds EX stalled until the result is valid.

## Interface
Parameters:
- MUL_LAT, 2: cycles from operands first presented to valid MUL/MULH/MULHU/MULHSU result (≥1)
- DIV_LAT, 8: cycles from operands first presented to valid DIV/DIVU/REM/REMU result (≥1)

Ports:
- ACLK  in  1  clock, all state on rising edge
- RESET  in  1  synchronous, active-low reset
- ex_valid  in  1  EX holds an instruction
- ex_aluop  in  5  ALU opcode (0–18, ALU encoding)
- ex_result  in  32  ALU result
- ex_store_data  in  32  rs2 value for stores
- ex_rd  in  5  destination register
- ex_regwrite  in  1  writes rd
- ex_memread  in  1  load
- ex_memwrite  in  1  store
- ex_funct3  in  3  load/store size/sign
- kill  in  1  discard the instruction in EX this cycle
- ex_stall  out  1  hold ID/EX register and ALU operands
- mem_ready  in  1  memory stage accepts this cycle
- mem_valid  out  1  EX/MEM register holds an instruction
- mem_result, mem_store_data  out  32 each  registered copies
- mem_rd  out  5; mem_regwrite, mem_memread, mem_memwrite  out  1; mem_funct3  out  3
- mem_illegal  out  1  captured op was an unsupported mul/div

## Operation
- Long ops: aluop 10–13 (latency MUL_LAT), 14–17 (latency DIV_LAT). All other opcodes are single-cycle.
- Output register free: free = !mem_valid | mem_ready.
- FSM states:
  - IDLE: no long op in progress.
  - BUSY: counter cnt tracks cycles elapsed for the EX long op.
- IDLE transitions:
  - ex_valid & single-cycle & free & !kill: capture.
  - ex_valid & long op & !kill: cnt←1, go to BUSY, ex_stall=1. No capture.
- BUSY behaviour:
  - done = (cnt == LAT of the current op).
  - done & free & !kill: capture, go to IDLE, cnt←0.
  - !done: cnt←cnt+1.
  - done & !free: cnt holds (saturates).
- ex_stall (combinational) = ex_valid & !kill & (long op & !done, including the IDLE arrival cycle | !free).
- Capture loads all mem_* fields from ex_*, sets mem_valid=1, mem_illegal=0.
- mem_ready & mem_valid with no capture: mem_valid←0. Data fields keep their values.
- kill: the instruction in EX is not captured, FSM→IDLE, cnt←0. The EX/MEM register is unaffected, so an already-captured instruction still drains. Kill on the same cycle as a would-be capture: kill wins.
- ex_valid low while in BUSY: abandon, go to IDLE, cnt←0.
- ex_aluop/operands must be stable while ex_stall=1. This is an upstream obligation and is not checked.

## Timing
- Reset (RESET=0 at an edge): mem_valid=0, mem_illegal=0, all mem_* data/control=0, FSM=IDLE, cnt=0. ex_stall=0 while in reset.
- Single-cycle op with free: captured at the end of the arrival cycle. mem_valid is visible on the next cycle (1-cycle latency).
- Long op arriving in cycle t, output free: ex_stall=1 in cycles t..t+LAT-1, capture at the end of cycle t+LAT, mem_valid high in cycle t+LAT+1.
- Back-to-back captures: 1 per cycle sustained when mem_ready=1.
- Reset asserted while in BUSY: the in-flight op is dropped with no capture.

## Configuration
- MULDIV_EN defined: long-op latency tracking as above. mem_illegal is always 0.
- MULDIV_EN undefined:
  - No counter and no BUSY state. MUL_LAT and DIV_LAT are ignored.
  - aluop 10–17 is captured as a single-cycle op with mem_illegal=1 and mem_regwrite forced to 0.
  - The ALU is built without its mul/div units.

## Test plan
- Reset, then ADD (aluop 0, result 0x5, rd 3), mem_ready=1 → mem_valid=1 next cycle with mem_result=0x5, mem_rd=3, ex_stall never asserted.
- MUL (aluop 10) with MUL_LAT=2, result 0x1E presented from the arrival cycle t → ex_stall high in t and t+1, capture at end of t+2, mem_result=0x1E.
- DIV (aluop 14) with DIV_LAT=8, mem_ready=0 during cycles t+8..t+10 while mem_valid=1 from an earlier op → ex_stall stays high through t+10, cnt saturates at 8, capture on the first mem_ready=1.
- DIV in BUSY at cnt=4, kill=1 → no capture, FSM to IDLE, next ADD captured in 1 cycle. A separate kill coinciding with a done MUL capture → not captured.
- RESET=0 asserted mid-DIV at cnt=3 → all mem_* = 0, ex_stall=0, following SUB captured normally.
- Without MULDIV_EN: MULHU (aluop 12), ex_regwrite=1 → captured in 1 cycle with mem_illegal=1, mem_regwrite=0.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// EX -> EX/MEM bundle: instruction fields from EX, kill/stall, and the EX/MEM register outputs.
// Latency: none (wires only).
// Backpressure: mem_ready from the memory stage, ex_stall back to EX.
//
// Port summary:
//   ex_valid, ex_aluop[4:0], ex_result[31:0], ex_store_data[31:0], ex_rd[4:0],
//   ex_regwrite, ex_memread, ex_memwrite, ex_funct3[2:0], kill  : EX -> stage
//   ex_stall                                                    : stage -> EX
//   mem_ready                                                   : MEM -> stage
//   mem_valid, mem_result, mem_store_data, mem_rd, mem_regwrite,
//   mem_memread, mem_memwrite, mem_funct3, mem_illegal          : stage -> MEM
// The stage uses the slave modport; the surrounding pipeline uses master.
interface ex_mem_stage_if;
  logic        ex_valid;
  logic [4:0]  ex_aluop;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [2:0]  ex_funct3;
  logic        kill;
  logic        ex_stall;
  logic        mem_ready;
  logic        mem_valid;
  logic [31:0] mem_result;
  logic [31:0] mem_store_data;
  logic [4:0]  mem_rd;
  logic        mem_regwrite;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [2:0]  mem_funct3;
  logic        mem_illegal;

  modport master (
    output ex_valid, ex_aluop, ex_result, ex_store_data, ex_rd,
           ex_regwrite, ex_memread, ex_memwrite, ex_funct3, kill, mem_ready,
    input  ex_stall, mem_valid, mem_result, mem_store_data, mem_rd,
           mem_regwrite, mem_memread, mem_memwrite, mem_funct3, mem_illegal
  );

  modport slave (
    input  ex_valid, ex_aluop, ex_result, ex_store_data, ex_rd,
           ex_regwrite, ex_memread, ex_memwrite, ex_funct3, kill, mem_ready,
    output ex_stall, mem_valid, mem_result, mem_store_data, mem_rd,
           mem_regwrite, mem_memread, mem_memwrite, mem_funct3, mem_illegal
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register; waits out pipelined mul/div latency before capturing.
// Latency: 1 cycle for single-cycle ops; LAT+1 cycles for mul/div (MULDIV_EN).
// Backpressure: holds EX via ex_stall while the EX/MEM register is full and mem_ready is low.
//
// Ports: ACLK (clock, rising edge), RESET (synchronous, active-low),
//        bus (ex_mem_stage_if.slave: EX inputs, kill, ex_stall, mem_ready, mem_* outputs).
// Build option: MULDIV_EN defined -> aluop 10..17 tracked for MUL_LAT/DIV_LAT cycles.
//               MULDIV_EN undefined -> aluop 10..17 captured at once, flagged mem_illegal
//               with mem_regwrite suppressed; MUL_LAT/DIV_LAT unused.
module ex_mem_stage #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input logic           ACLK,
  input logic           RESET,
  ex_mem_stage_if.slave bus
);

  logic is_mul;
  logic is_div;
  logic is_long;
  logic free;
  logic capture;
  logic cap_illegal;

  assign is_mul  = (bus.ex_aluop >= 5'd10) && (bus.ex_aluop <= 5'd13);
  assign is_div  = (bus.ex_aluop >= 5'd14) && (bus.ex_aluop <= 5'd17);
  assign is_long = is_mul || is_div;
  assign free    = !bus.mem_valid || bus.mem_ready;

`ifdef MULDIV_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] lat;
  logic          done;
  logic          go;

  assign lat  = is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
  // The IDLE arrival cycle is never done, so a long op always stalls at least once.
  assign done = (state == BUSY) && (cnt == lat);

  always_ff @(posedge ACLK) begin
    if (!RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!bus.ex_valid || bus.kill) begin
      // Killed or abandoned: drop any in-flight long op.
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_long) begin
            state_nxt = BUSY;
            cnt_nxt   = CW'(1);
          end
        end
        BUSY: begin
          if (!is_long || (done && free)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (!done) begin
            cnt_nxt = cnt + 1'b1;
          end
          // done && !free: cnt saturates at the latency until the register drains.
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    go           = bus.ex_valid && !bus.kill && RESET;
    bus.ex_stall = go && ((is_long && !done) || !free);
    capture      = go && free && (!is_long || done);
    cap_illegal  = 1'b0;
  end
`else
  assign bus.ex_stall = RESET && bus.ex_valid && !bus.kill && !free;
  assign capture      = RESET && bus.ex_valid && !bus.kill && free;
  // No mul/div hardware: such ops pass through flagged and must not write rd.
  assign cap_illegal  = is_long;
`endif

  always_ff @(posedge ACLK) begin
    if (!RESET) begin
      bus.mem_valid      <= 1'b0;
      bus.mem_result     <= '0;
      bus.mem_store_data <= '0;
      bus.mem_rd         <= '0;
      bus.mem_regwrite   <= 1'b0;
      bus.mem_memread    <= 1'b0;
      bus.mem_memwrite   <= 1'b0;
      bus.mem_funct3     <= '0;
      bus.mem_illegal    <= 1'b0;
    end else if (capture) begin
      bus.mem_valid      <= 1'b1;
      bus.mem_result     <= bus.ex_result;
      bus.mem_store_data <= bus.ex_store_data;
      bus.mem_rd         <= bus.ex_rd;
      bus.mem_regwrite   <= bus.ex_regwrite && !cap_illegal;
      bus.mem_memread    <= bus.ex_memread;
      bus.mem_memwrite   <= bus.ex_memwrite;
      bus.mem_funct3     <= bus.ex_funct3;
      bus.mem_illegal    <= cap_illegal;
    end else if (bus.mem_valid && bus.mem_ready) begin
      // Drained with nothing new: data fields keep their last values.
      bus.mem_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage; long-op scenarios run when MULDIV_EN is defined,
// otherwise the mul/div-as-illegal scenario runs.
module tb_ex_mem_stage;
  logic ACLK = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_errors = 0;

  ex_mem_stage_if bus ();

  ex_mem_stage #(.MUL_LAT(2), .DIV_LAT(8)) dut (
    .ACLK  (ACLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_op(input logic [4:0] op, input logic [31:0] res, input logic [4:0] rd,
                          input logic rw);
    bus.ex_valid      = 1'b1;
    bus.ex_aluop      = op;
    bus.ex_result     = res;
    bus.ex_store_data = ~res;
    bus.ex_rd         = rd;
    bus.ex_regwrite   = rw;
    bus.ex_memread    = 1'b0;
    bus.ex_memwrite   = 1'b0;
    bus.ex_funct3     = 3'd2;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    bus.kill = 1'b0;
    bus.mem_ready = 1'b1;
    drive_op(5'd0, 32'hDEAD, 5'd9, 1'b1);
    tick();
    tick();
    n_checks++; if (bus.mem_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", bus.mem_valid); end
    n_checks++; if (bus.mem_result !== 32'h0) begin n_errors++; $display("FAIL reset_result: got %h want 0", bus.mem_result); end
    n_checks++; if (bus.mem_rd !== 5'd0 || bus.mem_regwrite !== 1'b0 || bus.mem_funct3 !== 3'd0) begin
      n_errors++; $display("FAIL reset_ctrl: got rd=%0d rw=%b f3=%0d want 0", bus.mem_rd, bus.mem_regwrite, bus.mem_funct3); end
    n_checks++; if (bus.mem_illegal !== 1'b0) begin n_errors++; $display("FAIL reset_illegal: got %b want 0", bus.mem_illegal); end
    n_checks++; if (bus.ex_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", bus.ex_stall); end
    bus.ex_valid = 1'b0;
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_add();
    bus.mem_ready = 1'b1;
    drive_op(5'd0, 32'h5, 5'd3, 1'b1);
    #1;
    n_checks++; if (bus.ex_stall !== 1'b0) begin n_errors++; $display("FAIL add_stall: got %b want 0", bus.ex_stall); end
    tick();
    bus.ex_valid = 1'b0;
    n_checks++; if (bus.mem_valid !== 1'b1) begin n_errors++; $display("FAIL add_valid: got %b want 1", bus.mem_valid); end
    n_checks++; if (bus.mem_result !== 32'h5 || bus.mem_rd !== 5'd3) begin
      n_errors++; $display("FAIL add_data: got res=%h rd=%0d want 5/3", bus.mem_result, bus.mem_rd); end
    n_checks++; if (bus.mem_regwrite !== 1'b1 || bus.mem_illegal !== 1'b0 || bus.mem_store_data !== ~32'h5) begin
      n_errors++; $display("FAIL add_ctrl: got rw=%b ill=%b sd=%h want 1/0/fffffffa", bus.mem_regwrite, bus.mem_illegal, bus.mem_store_data); end
    tick();
    n_checks++; if (bus.mem_valid !== 1'b0) begin n_errors++; $display("FAIL add_drain: got %b want 0", bus.mem_valid); end
    n_checks++; if (bus.mem_result !== 32'h5) begin n_errors++; $display("FAIL add_keep: got %h want 5", bus.mem_result); end
  endtask

  task automatic test_back_to_back();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_op(5'd1, 32'h100 + i, 5'(i + 1), 1'b1);
      #1;
      n_checks++; if (bus.ex_stall !== 1'b0) begin n_errors++; $display("FAIL b2b_stall[%0d]: got %b want 0", i, bus.ex_stall); end
      tick();
      n_checks++; if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'h100 + i) begin
        n_errors++; $display("FAIL b2b_cap[%0d]: got v=%b res=%h want 1/%h", i, bus.mem_valid, bus.mem_result, 32'h100 + i); end
    end
    bus.ex_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    bus.mem_ready = 1'b0;
    drive_op(5'd2, 32'hA1, 5'd7, 1'b1);
    tick();
    n_checks++; if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'hA1) begin
      n_errors++; $display("FAIL bp_first: got v=%b res=%h want 1/a1", bus.mem_valid, bus.mem_result); end
    drive_op(5'd2, 32'hB2, 5'd8, 1'b1);
    #1;
    n_checks++; if (bus.ex_stall !== 1'b1) begin n_errors++; $display("FAIL bp_stall: got %b want 1", bus.ex_stall); end
    tick();
    n_checks++; if (bus.mem_result !== 32'hA1 || bus.mem_valid !== 1'b1) begin
      n_errors++; $display("FAIL bp_hold: got v=%b res=%h want 1/a1", bus.mem_valid, bus.mem_result); end
    bus.mem_ready = 1'b1;
    #1;
    n_checks++; if (bus.ex_stall !== 1'b0) begin n_errors++; $display("FAIL bp_release: got %b want 0", bus.ex_stall); end
    tick();
    bus.ex_valid = 1'b0;
    n_checks++; if (bus.mem_result !== 32'hB2 || bus.mem_rd !== 5'd8) begin
      n_errors++; $display("FAIL bp_second: got res=%h rd=%0d want b2/8", bus.mem_result, bus.mem_rd); end
    tick();
  endtask

  task automatic test_kill();
    bus.mem_ready = 1'b1;
    drive_op(5'd0, 32'hC3, 5'd4, 1'b1);
    bus.kill = 1'b1;
    #1;
    n_checks++; if (bus.ex_stall !== 1'b0) begin n_errors++; $display("FAIL kill_stall: got %b want 0", bus.ex_stall); end
    tick();
    n_checks++; if (bus.mem_valid !== 1'b0 || bus.mem_result !== 32'hB2) begin
      n_errors++; $display("FAIL kill_nocap: got v=%b res=%h want 0/b2", bus.mem_valid, bus.mem_result); end
    bus.kill = 1'b0;
    bus.mem_ready = 1'b0;
    drive_op(5'd0, 32'hD4, 5'd5, 1'b1);
    tick();
    drive_op(5'd0, 32'hE5, 5'd6, 1'b1);
    bus.kill = 1'b1;
    #1;
    n_checks++; if (bus.ex_stall !== 1'b0) begin n_errors++; $display("FAIL kill_full_stall: got %b want 0", bus.ex_stall); end
    tick();
    n_checks++; if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'hD4) begin
      n_errors++; $display("FAIL kill_drain: got v=%b res=%h want 1/d4", bus.mem_valid, bus.mem_result); end
    bus.kill = 1'b0;
    bus.ex_valid = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    n_checks++; if (bus.mem_valid !== 1'b0) begin n_errors++; $display("FAIL kill_empty: got %b want 0", bus.mem_valid); end
  endtask

`ifdef MULDIV_EN
  task automatic test_mul();
    bus.mem_ready = 1'b1;
    drive_op(5'd10, 32'h1E, 5'd5, 1'b1);
    #1;
    n_checks++; if (bus.ex_stall !== 1'b1) begin n_errors++; $display("FAIL mul_stall_t0: got %b want 1", bus.ex_stall); end
    tick();
    n_checks++; if (bus.ex_stall !== 1'b1 || bus.mem_valid !== 1'b0) begin
      n_errors++; $display("FAIL mul_t1: got stall=%b v=%b want 1/0", bus.ex_stall, bus.mem_valid); end
    tick();
    n_checks++; if (bus.ex_stall !== 1'b0 || bus.mem_valid !== 1'b0) begin
      n_errors++; $display("FAIL mul_t2: got stall=%b v=%b want 0/0", bus.ex_stall, bus.mem_valid); end
    tick();
    bus.ex_valid = 1'b0;
    n_checks++; if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'h1E || bus.mem_illegal !== 1'b0) begin
      n_errors++; $display("FAIL mul_cap: got v=%b res=%h ill=%b want 1/1e/0", bus.mem_valid, bus.mem_result, bus.mem_illegal); end
    tick();
  endtask

  task automatic test_div_backpressure();
    bus.mem_ready = 1'b0;
    drive_op(5'd0, 32'h11, 5'd1, 1'b1);
    tick();
    drive_op(5'd14, 32'h77, 5'd2, 1'b1);
    for (int k = 0; k <= 10; k++) begin
      #1;
      n_checks++; if (bus.ex_stall !== 1'b1 || bus.mem_result !== 32'h11) begin
        n_errors++; $display("FAIL div_hold[t+%0d]: got stall=%b res=%h want 1/11", k, bus.ex_stall, bus.mem_result); end
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    n_checks++; if (bus.ex_stall !== 1'b0) begin n_errors++; $display("FAIL div_release: got %b want 0", bus.ex_stall); end
    tick();
    bus.ex_valid = 1'b0;
    n_checks++; if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'h77) begin
      n_errors++; $display("FAIL div_cap: got v=%b res=%h want 1/77", bus.mem_valid, bus.mem_result); end
    tick();
  endtask

  task automatic test_kill_busy();
    bus.mem_ready = 1'b1;
    drive_op(5'd15, 32'h44, 5'd3, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    bus.kill = 1'b1;
    #1;
    n_checks++; if (bus.ex_stall !== 1'b0) begin n_errors++; $display("FAIL killbusy_stall: got %b want 0", bus.ex_stall); end
    tick();
    bus.kill = 1'b0;
    n_checks++; if (bus.mem_valid !== 1'b0) begin n_errors++; $display("FAIL killbusy_nocap: got %b want 0", bus.mem_valid); end
    drive_op(5'd0, 32'h33, 5'd4, 1'b1);
    #1;
    n_checks++; if (bus.ex_stall !== 1'b0) begin n_errors++; $display("FAIL killbusy_add_stall: got %b want 0", bus.ex_stall); end
    tick();
    bus.ex_valid = 1'b0;
    n_checks++; if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'h33) begin
      n_errors++; $display("FAIL killbusy_add: got v=%b res=%h want 1/33", bus.mem_valid, bus.mem_result); end
    tick();
    // Kill exactly on the cycle a MUL would be captured.
    drive_op(5'd11, 32'h55, 5'd6, 1'b1);
    tick();
    tick();
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    bus.ex_valid = 1'b0;
    n_checks++; if (bus.mem_valid !== 1'b0 || bus.mem_result !== 32'h33) begin
      n_errors++; $display("FAIL killdone: got v=%b res=%h want 0/33", bus.mem_valid, bus.mem_result); end
    tick();
  endtask

  task automatic test_reset_busy();
    bus.mem_ready = 1'b1;
    drive_op(5'd16, 32'h66, 5'd7, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    RESET = 1'b0;
    #1;
    n_checks++; if (bus.ex_stall !== 1'b0) begin n_errors++; $display("FAIL rstbusy_stall: got %b want 0", bus.ex_stall); end
    tick();
    n_checks++; if (bus.mem_valid !== 1'b0 || bus.mem_result !== 32'h0 || bus.mem_rd !== 5'd0 || bus.mem_store_data !== 32'h0) begin
      n_errors++; $display("FAIL rstbusy_clear: got v=%b res=%h rd=%0d sd=%h want all 0", bus.mem_valid, bus.mem_result, bus.mem_rd, bus.mem_store_data); end
    RESET = 1'b1;
    bus.ex_valid = 1'b0;
    tick();
    drive_op(5'd1, 32'h99, 5'd8, 1'b1);
    #1;
    n_checks++; if (bus.ex_stall !== 1'b0) begin n_errors++; $display("FAIL rstbusy_sub_stall: got %b want 0", bus.ex_stall); end
    tick();
    bus.ex_valid = 1'b0;
    n_checks++; if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'h99) begin
      n_errors++; $display("FAIL rstbusy_sub: got v=%b res=%h want 1/99", bus.mem_valid, bus.mem_result); end
    tick();
  endtask
`else
  task automatic test_illegal();
    logic [4:0] ops [5]     = '{5'd12, 5'd10, 5'd17, 5'd18, 5'd9};
    logic       exp_ill [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_op(ops[i], 32'h200 + i, 5'd10, 1'b1);
      #1;
      n_checks++; if (bus.ex_stall !== 1'b0) begin n_errors++; $display("FAIL ill_stall[%0d]: got %b want 0", i, bus.ex_stall); end
      tick();
      n_checks++; if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'h200 + i) begin
        n_errors++; $display("FAIL ill_cap[%0d]: got v=%b res=%h want 1/%h", i, bus.mem_valid, bus.mem_result, 32'h200 + i); end
      n_checks++; if (bus.mem_illegal !== exp_ill[i] || bus.mem_regwrite !== !exp_ill[i]) begin
        n_errors++; $display("FAIL ill_flag[%0d]: got ill=%b rw=%b want %b/%b", i, bus.mem_illegal, bus.mem_regwrite, exp_ill[i], !exp_ill[i]); end
    end
    bus.ex_valid = 1'b0;
    tick();
  endtask
`endif

  initial begin
    bus.ex_valid = 1'b0;
    bus.kill = 1'b0;
    bus.mem_ready = 1'b1;
    drive_op(5'd0, 32'h0, 5'd0, 1'b0);
    bus.ex_valid = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_kill();
`ifdef MULDIV_EN
    test_mul();
    test_div_backpressure();
    test_kill_busy();
    test_reset_busy();
`else
    test_illegal();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
